// File: rtl/serial_add_ctrl_if.sv
// Handshake and sync_FA link bundle for the bit-serial adder controller.
// Master drives requests and the full-adder return path; slave is the controller.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry_in;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;

   modport master (
      output start, op_a, op_b, carry_in,
      output fa_sum, fa_cout,
      input  fa_a, fa_b, fa_cin,
      input  busy, done, result, carry_out
   );

   modport slave (
      input  start, op_a, op_b, carry_in,
      input  fa_sum, fa_cout,
      output fa_a, fa_b, fa_cin,
      output busy, done, result, carry_out
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller feeding a registered full adder LSB-first.
// Sum bits return one cycle late and are shifted in from the MSB side.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_add_ctrl_if.slave  bus
);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_cin;
   logic             r_fa_a;
   logic             r_fa_b;
   logic             r_cout;
   logic             r_done;
   logic             w_last;
   logic             w_busy;
   logic             w_fa_cin;

   assign w_last = (r_idx == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (bus.start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DRAIN;
         S_DRAIN: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Bit 0 takes the latched carry-in; later bits chain the FA's own carry.
   always_comb begin
      w_busy   = 1'b0;
      w_fa_cin = 1'b0;
      unique case (r_state)
         S_RUN: begin
            w_busy   = 1'b1;
            w_fa_cin = (r_idx == '0) ? r_cin : bus.fa_cout;
         end
         S_DRAIN: w_busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_cin  <= 1'b0;
         r_fa_a <= 1'b0;
         r_fa_b <= 1'b0;
         r_cout <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a    <= bus.op_a >> 1;
                  r_b    <= bus.op_b >> 1;
                  r_cin  <= bus.carry_in;
                  r_fa_a <= bus.op_a[0];
                  r_fa_b <= bus.op_b[0];
                  r_idx  <= '0;
               end
            end
            S_RUN: begin
               r_idx  <= w_last ? '0 : r_idx + 1'b1;
               r_fa_a <= w_last ? 1'b0 : r_a[0];
               r_fa_b <= w_last ? 1'b0 : r_b[0];
               r_a    <= r_a >> 1;
               r_b    <= r_b >> 1;
               // fa_sum is stale on the first RUN edge
               if (r_idx != '0)
                  r_res <= {bus.fa_sum, r_res[WIDTH-1:1]};
            end
            S_DRAIN: begin
               r_res  <= {bus.fa_sum, r_res[WIDTH-1:1]};
               r_cout <= bus.fa_cout;
               r_done <= 1'b1;
               r_fa_a <= 1'b0;
               r_fa_b <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.fa_a      = r_fa_a;
   assign bus.fa_b      = r_fa_b;
   assign bus.fa_cin    = w_fa_cin;
   assign bus.busy      = w_busy;
   assign bus.done      = r_done;
   assign bus.result    = r_res;
   assign bus.carry_out = r_cout;
endmodule
